flappy_game_engine: RTL and testbench

- Game-state and physics stage directly upstream of the VGA wrapper.
- Produces bird_1_height, pipe_height, start_game and end_game, which feed the wrapper's identically named inputs.
- Advances game state once per video frame, triggered by the vsync output of the VGA timer.
- Handles flap input, gravity, pipe scrolling, pseudo-random pipe gaps, collision and score.

---
 rtl/flappy_game_engine.sv | 173 +++++++++++++++++
 tb/tb_flappy_game_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_engine.sv
// Per-frame bird physics, pipe scrolling, collision and score for the VGA wrapper.
// State advances on a synchronized vsync rising edge; outputs are registered (one clk after the tick); no backpressure.
module flappy_game_engine #(
   parameter int BIRD_START  = 100,
   parameter int FLOOR       = 200,
   parameter int GRAVITY     = 1,
   parameter int FLAP_VEL    = 6,
   parameter int MAX_FALL    = 7,
   parameter int BIRD_X      = 100,
   parameter int BIRD_SIZE   = 8,
   parameter int PIPE_W      = 20,
   parameter int GAP         = 60,
   parameter int PIPE_START  = 639,
   parameter int PIPE_SPEED  = 2,
   parameter int PIPE_MIN    = 10,
   parameter int LFSR_SEED   = 8'hA5,
   parameter int DEAD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       vsync,
   input  logic       flap,
   output logic       start_game,
   output logic       end_game,
   output logic [7:0] bird_1_height,
   output logic [7:0] pipe_height,
   output logic [9:0] pipe_x,
   output logic [7:0] score
);

   typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

   localparam logic [7:0]        BIRD_RST = 8'(BIRD_START);
   localparam logic [7:0]        FLOOR_H  = 8'(FLOOR);
   localparam logic signed [9:0] POS_FLR  = 10'(FLOOR);
   localparam logic signed [5:0] VEL_FLAP = 6'(-FLAP_VEL);
   localparam logic signed [5:0] VEL_GRAV = 6'(GRAVITY);
   localparam logic signed [5:0] VEL_MAX  = 6'(MAX_FALL);
   localparam logic [9:0]        PX_START = 10'(PIPE_START);
   localparam logic [9:0]        PX_SPEED = 10'(PIPE_SPEED);
   localparam logic [7:0]        SEED     = 8'(LFSR_SEED);
   localparam logic [7:0]        PH_RST   = 8'(PIPE_MIN) + {1'b0, SEED[6:0]};
   localparam logic [5:0]        DEAD_MAX = 6'(DEAD_FRAMES);

   state_t            state, state_n;
   logic signed [5:0] vel, vel_n, vel_inc;
   logic [7:0]        lfsr, lfsr_n, lfsr_step;
   logic [7:0]        bird_n, ph_n, score_n;
   logic [9:0]        px_n;
   logic [5:0]        dead_cnt, dead_n;
   logic signed [9:0] pos;
   logic              hit_x, hit_y;
   logic              flap_pending;
   logic [2:0]        vs_sync, fl_sync;
   logic              frame_tick, flap_edge;

   // Both inputs are asynchronous to clk; the third stage only feeds edge detection.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         vs_sync <= 3'b111;
         fl_sync <= 3'b000;
      end else begin
         vs_sync <= {vs_sync[1:0], vsync};
         fl_sync <= {fl_sync[1:0], flap};
      end
   end

   assign frame_tick = vs_sync[1] & ~vs_sync[2];
   assign flap_edge  = fl_sync[1] & ~fl_sync[2];
   assign lfsr_step  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   // Every tick either consumes or discards the pending flap, so it restarts from this cycle's edge.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear)          flap_pending <= 1'b0;
      else if (frame_tick) flap_pending <= flap_edge;
      else                 flap_pending <= flap_pending | flap_edge;
   end

   always_comb begin
      state_n = state;
      vel_n   = vel;
      bird_n  = bird_1_height;
      px_n    = pipe_x;
      ph_n    = pipe_height;
      lfsr_n  = lfsr;
      score_n = score;
      dead_n  = dead_cnt;
      vel_inc = vel + VEL_GRAV;
      pos     = '0;
      hit_x   = 1'b0;
      hit_y   = 1'b0;
      if (frame_tick) begin
         case (state)
            IDLE: begin
               if (flap_pending) begin
                  state_n = PLAY;
                  vel_n   = VEL_FLAP;
                  score_n = '0;
               end
            end
            PLAY: begin
               if (flap_pending)          vel_n = VEL_FLAP;
               else if (vel_inc > VEL_MAX) vel_n = VEL_MAX;
               else                        vel_n = vel_inc;

               pos = $signed({2'b00, bird_1_height}) + 10'(vel_n);
               if (pos[9]) begin
                  bird_n = '0;
                  vel_n  = '0;
               end else if (pos >= POS_FLR) begin
                  bird_n  = FLOOR_H;
                  state_n = DEAD;
               end else begin
                  bird_n = pos[7:0];
               end

               if (pipe_x < PX_SPEED) begin
                  px_n    = PX_START;
                  lfsr_n  = lfsr_step;
                  ph_n    = 8'(PIPE_MIN) + {1'b0, lfsr_step[6:0]};
                  score_n = (score == 8'hFF) ? score : score + 8'd1;
               end else begin
                  px_n = pipe_x - PX_SPEED;
               end

               // Collision is judged on this tick's updated bird and pipe.
               hit_x = (px_n <= 10'(BIRD_X + BIRD_SIZE)) && ((px_n + 10'(PIPE_W)) >= 10'(BIRD_X));
               hit_y = (bird_n < ph_n) ||
                       (({2'b00, bird_n} + 10'(BIRD_SIZE)) > ({2'b00, ph_n} + 10'(GAP)));
               if (hit_x && hit_y) state_n = DEAD;
            end
            DEAD: begin
               if (dead_cnt != DEAD_MAX) dead_n = dead_cnt + 6'd1;
               if (dead_cnt == DEAD_MAX && flap_pending) begin
                  state_n = IDLE;
                  bird_n  = BIRD_RST;
                  vel_n   = '0;
                  px_n    = PX_START;
                  dead_n  = '0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state         <= IDLE;
         vel           <= '0;
         bird_1_height <= BIRD_RST;
         pipe_x        <= PX_START;
         pipe_height   <= PH_RST;
         lfsr          <= SEED;
         score         <= '0;
         dead_cnt      <= '0;
         start_game    <= 1'b0;
         end_game      <= 1'b0;
      end else begin
         state         <= state_n;
         vel           <= vel_n;
         bird_1_height <= bird_n;
         pipe_x        <= px_n;
         pipe_height   <= ph_n;
         lfsr          <= lfsr_n;
         score         <= score_n;
         dead_cnt      <= dead_n;
         start_game    <= (state_n == PLAY);
         end_game      <= (state_n == DEAD);
      end
   end

endmodule

// File: tb/tb_flappy_game_engine.sv
// Directed bench for flappy_game_engine: frames are generated by pulsing vsync low, flaps by pulsing flap.
module tb_flappy_game_engine;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       vsync = 1'b1;
   logic       flap = 1'b0;
   logic       start_game, end_game;
   logic [7:0] bird_1_height, pipe_height, score;
   logic [9:0] pipe_x;

   int n_checks = 0;
   int n_errors = 0;

   flappy_game_engine dut (
      .clk           (clk),
      .clear         (clear),
      .vsync         (vsync),
      .flap          (flap),
      .start_game    (start_game),
      .end_game      (end_game),
      .bird_1_height (bird_1_height),
      .pipe_height   (pipe_height),
      .pipe_x        (pipe_x),
      .score         (score)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_flap();
      @(negedge clk) flap = 1'b1;
      repeat (3) @(negedge clk);
      flap = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // One video frame; outputs have settled when this returns (sampled at a negedge).
   task automatic frame(input bit f);
      if (f) pulse_flap();
      @(negedge clk) vsync = 1'b0;
      repeat (4) @(negedge clk);
      vsync = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk) clear = 1'b0;
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_score);
      check({tag, "_start"}, start_game, 0);
      check({tag, "_end"}, end_game, 0);
      check({tag, "_bird"}, bird_1_height, 100);
      check({tag, "_pipe_x"}, pipe_x, 639);
      check({tag, "_score"}, score, exp_score);
   endtask

   int exp_fall [13] = '{95, 91, 88, 86, 85, 85, 86, 88, 91, 95, 100, 106, 113};

   initial begin
      bit f;
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);

      // Reset state and idle frames
      check_idle("rst", 0);
      check("rst_ph", pipe_height, 47);
      for (int i = 0; i < 5; i++) frame(0);
      check_idle("idle5", 0);
      check("idle5_ph", pipe_height, 47);

      // Game 1: single flap then free fall to the floor
      frame(1);
      check("g1_start", start_game, 1);
      check("g1_start_bird", bird_1_height, 100);
      check("g1_start_px", pipe_x, 639);
      for (int k = 1; k <= 13; k++) begin
         frame(0);
         check($sformatf("g1_bird_t%0d", k), bird_1_height, exp_fall[k-1]);
      end
      check("g1_px_t13", pipe_x, 613);
      for (int k = 14; k <= 25; k++) frame(0);
      check("g1_bird_t25", bird_1_height, 197);
      check("g1_alive_t25", start_game, 1);
      frame(0);
      check("g1_floor_bird", bird_1_height, 200);
      check("g1_floor_end", end_game, 1);
      check("g1_floor_start", start_game, 0);
      check("g1_floor_px", pipe_x, 587);
      frame(0);
      frame(1);
      check("g1_frozen_bird", bird_1_height, 200);
      check("g1_frozen_px", pipe_x, 587);
      check("g1_frozen_end", end_game, 1);

      // Game 2: flap every tick up into the ceiling clamp
      do_clear();
      check_idle("clr1", 0);
      frame(1);
      for (int k = 1; k <= 16; k++) frame(1);
      check("g2_bird_4", bird_1_height, 4);
      frame(1);
      check("g2_clamp", bird_1_height, 0);
      frame(0);
      check("g2_vel0_after_clamp", bird_1_height, 1);
      frame(0);
      check("g2_bird_3", bird_1_height, 3);
      frame(1);
      check("g2_clamp_from3", bird_1_height, 0);
      frame(0);
      check("g2_after_clamp2", bird_1_height, 1);
      check("g2_alive", start_game, 1);

      // Clear with a flap pending: the flap must be lost
      pulse_flap();
      do_clear();
      check_idle("clr2", 0);
      check("clr2_ph", pipe_height, 47);
      frame(0);
      check("clr2_flap_lost", start_game, 0);

      // Game 3: hover through the first pipe, wrap, then collide with the second
      frame(1);
      for (int k = 1; k <= 586; k++) begin
         f = (k == 1) || (k >= 2 && ((k - 2) % 13) == 0) || (k == 586);
         frame(f);
         if (k == 280) check("g3_pipe1_passed", start_game, 1);
         if (k == 319) begin
            check("g3_px_1", pipe_x, 1);
            check("g3_bird_319", bird_1_height, 73);
            check("g3_score_0", score, 0);
            check("g3_ph_47", pipe_height, 47);
         end
         if (k == 320) begin
            check("g3_wrap_px", pipe_x, 639);
            check("g3_wrap_score", score, 1);
            check("g3_wrap_ph", pipe_height, 84);
            check("g3_wrap_alive", start_game, 1);
         end
         if (k == 585) begin
            check("g3_px_109", pipe_x, 109);
            check("g3_no_overlap_alive", start_game, 1);
            check("g3_bird_585", bird_1_height, 88);
         end
      end
      check("g3_hit_end", end_game, 1);
      check("g3_hit_start", start_game, 0);
      check("g3_hit_bird", bird_1_height, 82);
      check("g3_hit_px", pipe_x, 107);
      check("g3_hit_score", score, 1);

      // DEAD hold-off: flaps before saturation are discarded
      for (int d = 1; d <= 62; d++) begin
         frame(d == 31 || d == 60 || d == 62);
         if (d == 31) begin
            check("dead_flap30_ignored", end_game, 1);
            check("dead_frozen_bird", bird_1_height, 82);
            check("dead_frozen_px", pipe_x, 107);
         end
         if (d == 60) check("dead_flap59_ignored", end_game, 1);
         if (d == 61) check("dead_no_pending", end_game, 1);
      end
      check_idle("ret", 1);
      frame(0);
      check("ret_score_held", score, 1);
      check("ret_idle", start_game, 0);
      frame(1);
      check("new_game_start", start_game, 1);
      check("new_game_score", score, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
